fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit CPU, directly upstream of the opcode control decoder. Maintains the program counter and issues word reads to instruction memory over a request/grant/response handshake. Buffers returned instructions in a small FIFO and presents them, with their PC and 4-bit opcode field, to decode under valid/ready. Taken branches and jumps redirect the PC, flush the FIFO and discard any in-flight response.

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake, instruction FIFO to decode.
// Define FETCH_BYPASS_EN to present a returning word to decode in the same cycle.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [15:0]       imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [15:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [3:0]        opcode
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] req_pc;
   logic [15:0]       mem_d  [DEPTH];
   logic [ADDR_W-1:0] mem_pc [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [PW:0]       count;

   logic head_v;
   logic byp;
   logic pop;
   logic push;
   logic grant;

   assign head_v = rst_n && (count != '0);
   assign pop    = head_v && instr_ready;

`ifdef FETCH_BYPASS_EN
   assign byp = rst_n && (state == WAIT) && (count == '0)
                && imem_rvalid && !redirect;
`else
   assign byp = 1'b0;
`endif

   // A bypassed word consumed this cycle never occupies a slot
   assign push = rst_n && (state == WAIT) && imem_rvalid
                 && !redirect && !(byp && instr_ready);

   assign imem_req = rst_n && (state == IDLE)
                     && (count < FULL) && !redirect;
   assign imem_addr = imem_req ? pc : '0;
   assign grant     = imem_req && imem_gnt;

   assign instr_valid = head_v || byp;
   assign opcode      = instr[15:12];

   always_comb begin
      instr    = '0;
      instr_pc = '0;
      unique case (1'b1)
         head_v: begin
            instr    = mem_d[rd_ptr];
            instr_pc = mem_pc[rd_ptr];
         end
         byp: begin
            instr    = imem_rdata;
            instr_pc = req_pc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_d[wr_ptr]  <= imem_rdata;
         mem_pc[wr_ptr] <= req_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (redirect) begin
            pc <= redirect_pc;
         end else if (grant) begin
            pc <= pc + 1'b1;
         end
         if (grant) begin
            req_pc <= pc;
         end

         unique case (state)
            IDLE: begin
               if (grant) state <= WAIT;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  state <= IDLE;
               end else if (redirect) begin
                  state <= DROP;
               end
            end
            DROP: begin
               if (imem_rvalid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push}
                           - {{PW{1'b0}}, pop};
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, queue-based reference model,
// opcode vector table and directed redirect/reset sequences.
module tb_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        redirect;
   logic [7:0]  redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic [3:0]  opcode;

   logic        b_req;
   logic [7:0]  b_addr;
   logic        b_gnt;
   logic        b_rvalid;
   logic [15:0] b_rdata;
   logic        b_redir;
   logic [7:0]  b_rpc;
   logic        b_ivalid;
   logic        b_ready;
   logic [15:0] b_instr;
   logic [7:0]  b_ipc;
   logic [3:0]  b_op;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
   );

   fetch_unit #(.RESET_PC(8'hFE)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .imem_req(b_req), .imem_addr(b_addr),
      .imem_gnt(b_gnt), .imem_rvalid(b_rvalid),
      .imem_rdata(b_rdata),
      .redirect(b_redir), .redirect_pc(b_rpc),
      .instr_valid(b_ivalid), .instr_ready(b_ready),
      .instr(b_instr), .instr_pc(b_ipc), .opcode(b_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rdata;
      logic [3:0]  op;
   } vec_t;

   typedef struct packed {
      logic [7:0]  pc;
      logic [15:0] d;
   } ent_t;

   int checks = 0;
   int errors = 0;

   logic [15:0] img [256];

   int  gnt_mode;
   int  k_lat;
   bit  k_rand;
   bit  ready_v;

   bit         m_pend;
   int         m_cnt;
   logic [7:0] m_addr;

   ent_t       q[$];
   bit         outst;
   bit         dropped;
   logic [7:0] mpc;
   logic [7:0] rpc_m;

   bit          granted;
   bit          popped;
   logic [7:0]  g_addr;
   logic [7:0]  p_pc;
   logic [15:0] p_instr;
   logic [3:0]  p_op;
   logic        o_req;
   logic [7:0]  o_addr;

   bit         b_pend;
   logic [7:0] b_addrs[$];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [7:0] rp);
      bit exp_v;
      bit exp_req;
      redirect    = r;
      redirect_pc = rp;
      instr_ready = ready_v;
      if (m_pend && m_cnt > 0) m_cnt--;
      imem_rvalid = m_pend && (m_cnt == 0);
      imem_rdata  = imem_rvalid ? img[m_addr] : 16'($urandom);
      case (gnt_mode)
         1:       imem_gnt = 1'b1;
         2:       imem_gnt = ($urandom_range(0, 3) != 0);
         default: imem_gnt = 1'b0;
      endcase
      b_gnt    = 1'b1;
      b_rvalid = b_pend;
      b_rdata  = 16'($urandom);
      #1;
      o_req   = imem_req;
      o_addr  = imem_addr;
      exp_v   = (q.size() != 0);
      exp_req = !outst && (q.size() < 2) && !r;
      granted = imem_req && imem_gnt;
      g_addr  = imem_addr;
      popped  = 1'b0;
      if (rst_n) begin
         chk("instr_valid", instr_valid, exp_v);
         if (exp_v) begin
            chk("instr_pc", instr_pc, q[0].pc);
            chk("instr", instr, q[0].d);
            chk("opcode", opcode, q[0].d[15:12]);
         end
         chk("imem_req", imem_req, exp_req);
         if (exp_req) chk("imem_addr", imem_addr, mpc);
      end
      if (imem_rvalid) m_pend = 1'b0;
      if (imem_req && imem_gnt) begin
         m_pend = 1'b1;
         m_cnt  = k_rand ? $urandom_range(1, 3) : k_lat;
         m_addr = imem_addr;
      end
      if (!rst_n) begin
         q.delete();
         outst   = 1'b0;
         dropped = 1'b0;
         mpc     = 8'h00;
         b_pend  = 1'b0;
      end else begin
         if (exp_v && ready_v) begin
            popped  = 1'b1;
            p_pc    = instr_pc;
            p_instr = instr;
            p_op    = opcode;
            void'(q.pop_front());
         end
         if (imem_rvalid && outst) begin
            if (!dropped && !r) q.push_back('{rpc_m, img[rpc_m]});
            outst   = 1'b0;
            dropped = 1'b0;
         end
         if (r) begin
            q.delete();
            mpc = rp;
            if (outst) dropped = 1'b1;
         end
         if (exp_req && imem_gnt) begin
            outst = 1'b1;
            rpc_m = mpc;
            mpc   = mpc + 8'd1;
         end
         if (b_req && b_gnt) b_addrs.push_back(b_addr);
         b_pend = b_req && b_gnt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero();
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_opcode", opcode, 0);
   endtask

   task automatic do_reset();
      int t;
      b_addrs.delete();
      rst_n    = 1'b0;
      gnt_mode = 0;
      repeat (2) step(1'b0, 8'h00);
      chk_zero();
      rst_n = 1'b1;
      t = 0;
      while (m_pend && t < 10) begin
         step(1'b0, 8'h00);
         t++;
      end
   endtask

   task automatic until_grant(input string nm);
      int t;
      t = 0;
      do begin
         step(1'b0, 8'h00);
         t++;
      end while (!granted && t < 30);
      chk(nm, granted, 1);
   endtask

   task automatic until_pop(input string nm);
      int t;
      t = 0;
      do begin
         step(1'b0, 8'h00);
         t++;
      end while (!popped && t < 30);
      chk(nm, popped, 1);
   endtask

   vec_t tv[6];

   initial begin
      int ng;
      int cnt;
      logic [7:0] rp;
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      instr_ready = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      b_gnt       = 1'b0;
      b_rvalid    = 1'b0;
      b_rdata     = '0;
      b_redir     = 1'b0;
      b_rpc       = '0;
      b_ready     = 1'b1;
      gnt_mode    = 0;
      k_lat       = 1;
      k_rand      = 1'b0;
      ready_v     = 1'b0;
      m_pend      = 1'b0;
      m_cnt       = 0;
      m_addr      = '0;
      outst       = 1'b0;
      dropped     = 1'b0;
      mpc         = '0;
      rpc_m       = '0;
      b_pend      = 1'b0;
      p_pc        = '0;
      p_instr     = '0;
      p_op        = '0;
      for (int i = 0; i < 256; i++) img[i] = 16'($urandom);

      tv[0] = '{16'h5123, 4'h5};
      tv[1] = '{16'hF000, 4'hF};
      tv[2] = '{16'h0FFF, 4'h0};
      tv[3] = '{16'hA5A5, 4'hA};
      tv[4] = '{16'h7001, 4'h7};
      tv[5] = '{16'h1234, 4'h1};
      for (int i = 0; i < 6; i++) img[i] = tv[i].rdata;

      @(posedge clk);
      #1;

      // opcode table, back-to-back fetch from reset
      do_reset();
      gnt_mode = 1;
      k_lat    = 1;
      ready_v  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         until_pop("tbl_pop");
         chk("tbl_pc", p_pc, i);
         chk("tbl_instr", p_instr, tv[i].rdata);
         chk("tbl_opcode", p_op, tv[i].op);
      end
      chk("wrap_n", b_addrs.size() >= 3, 1);
      if (b_addrs.size() >= 3) begin
         chk("wrap_a0", b_addrs[0], 8'hFE);
         chk("wrap_a1", b_addrs[1], 8'hFF);
         chk("wrap_a2", b_addrs[2], 8'h00);
      end

      // backpressure fills exactly DEPTH entries
      do_reset();
      gnt_mode = 1;
      ready_v  = 1'b0;
      ng = 0;
      repeat (12) begin
         step(1'b0, 8'h00);
         if (granted) ng++;
      end
      chk("buf_grants", ng, 2);
      chk("buf_req", o_req, 0);
      ready_v = 1'b1;
      until_grant("resume_grant");
      chk("resume_addr", g_addr, 8'h02);

      // redirect while waiting, stale data returns later
      do_reset();
      gnt_mode = 1;
      k_lat    = 3;
      ready_v  = 1'b1;
      until_grant("drop_g0");
      step(1'b1, 8'h40);
      cnt = 0;
      do begin
         step(1'b0, 8'h00);
         cnt++;
      end while (!granted && cnt < 30);
      chk("drop_wait", cnt, 3);
      chk("drop_addr", g_addr, 8'h40);
      until_pop("drop_pop");
      chk("drop_first_pc", p_pc, 8'h40);

      // redirect in the same cycle as the response
      k_lat = 1;
      until_grant("rvr_g0");
      step(1'b1, 8'h80);
      step(1'b0, 8'h00);
      chk("rvr_req", o_req, 1);
      chk("rvr_addr", o_addr, 8'h80);
      until_pop("rvr_pop");
      chk("rvr_first_pc", p_pc, 8'h80);

      // reset while waiting; response lands during reset
      k_lat = 4;
      until_grant("rw_g0");
      rst_n    = 1'b0;
      gnt_mode = 0;
      repeat (4) begin
         step(1'b0, 8'h00);
         chk_zero();
      end
      chk("rw_drained", m_pend, 0);
      rst_n    = 1'b0;
      rst_n    = 1'b1;
      gnt_mode = 1;
      until_grant("rw_g1");
      chk("rw_addr", g_addr, 8'h00);
      until_pop("rw_pop");
      chk("rw_pc", p_pc, 8'h00);
      chk("rw_instr", p_instr, tv[0].rdata);

      // randomized traffic against the reference queue
      do_reset();
      gnt_mode = 2;
      k_rand   = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         ready_v = ($urandom_range(0, 3) != 0);
         rp = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rp = 8'hFC | rp[1:0];
         step($urandom_range(0, 11) == 0, rp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
